fsoc_gpio: RTL and testbench
============================

# fsoc_gpio

Single-bit general-purpose I/O peripheral with a Wishbone-classic slave port. It sits on the SoC data bus beside the RAM, and software reaches it through a single 32-bit register. The SoC interconnect routes data-bus accesses with address bit 28 set (0x1xxxxxxx) to this block. It drives one output pin from a software-written latch and returns a synchronized sample of one input pin on reads.

## Interface
- `SYNC_STAGES`, default 2: number of flip-flops in the `gpi_i` synchronizer chain; legal values are 2 or more.
- `GPO_RESET`, default 1'b0: value of the output latch after reset.

Ports:
- `clk_i`  in  1  system clock; all state changes on its rising edge.
- `rst_in`  in  1  reset, asynchronous and active-low.
- `cyc_i`  in  1  Wishbone cycle valid.
- `stb_i`  in  1  Wishbone strobe.
- `we_i`  in  1  1 = write, 0 = read.
- `be_i`  in  4  byte enables.
- `dat_i`  in  32  write data.
- `dat_o`  out  32  read data.
- `ack_o`  out  1  transfer acknowledge.
- `gpi_i`  in  1  asynchronous input pin.
- `gpo_o`  out  1  output pin.

## Operation
- The block has no address decode. Every selected access targets the single register; the block has no address input.
- Register layout:
  - Write bit 0 is the output latch.
  - Read bit 0 is the synchronized input, read bit 1 is the current output latch, and bits 31:2 read as 0.
- An access is accepted when `cyc_i & stb_i & ~ack_o` is high at a rising edge.
- On an accepted write with `be_i[0]=1`, the latch takes `dat_i[0]`. With `be_i[0]=0`, the write is acknowledged and the latch is unchanged. `be_i[3:1]` are ignored.
- On every accepted access, read or write, the read data is registered: `dat_o <= {30'b0, gpo_latch_pre_write, gpi_sync}`.
- `gpo_o` is driven directly from the latch register, with no combinational path from the bus.
- `gpi_i` passes through a `SYNC_STAGES`-deep flip-flop chain. `gpi_sync` is the last stage.
- `dat_o` holds its value between accesses. Consumers must only sample it while `ack_o` is high.
- Reset (`rst_in=0`), asynchronous:
  - `ack_o=0` and `dat_o=0`.
  - The latch loads `GPO_RESET`, so `gpo_o=GPO_RESET`.
  - All synchronizer stages are cleared to 0.
- Reset taking effect in the middle of an access aborts that access: no ack is issued and no latch update occurs. After reset is released, a master still holding `stb_i` is treated as presenting a new access.

## Timing
- Ack latency is 1 cycle. For an access presented in cycle N (strobe sampled at the edge ending cycle N), `ack_o` is high for exactly cycle N+1.
- `ack_o` is forced low in the cycle after an ack, even if `cyc_i & stb_i` remain high. A held strobe therefore yields at most one ack every 2 cycles.
- Back-to-back accesses produce the ack pattern 1,0,1,0,…
- `gpo_o` changes at the same edge that raises `ack_o` for the write.
- Input latency: a `gpi_i` transition appears on `gpi_sync` after `SYNC_STAGES` edges, i.e. 2 edges by default. It appears in `dat_o` at the first accepted read after that.
- Write and read in the same access: `dat_o[1]` returns the latch value before the write takes effect.
- If `cyc_i=0` or `stb_i=0`, no state changes other than the synchronizer shifting.

## Structure
- No shared package is needed. The bit positions for GPI (0) and GPO (1) are localparams inside the module.
- Natural sub-module: `sync_ff`, a parameterized N-stage reset-clearable synchronizer with ports `clk_i`, `rst_in`, `d_i`, `q_o`. It is reused by other SoC peripherals.
- The top level contains the ack flag, the output latch, the read-data register, and the accept logic.

## Test plan
- Reset values: hold `rst_in=0` while toggling the bus. Expect `ack_o=0`, `dat_o=0`, `gpo_o=0`. Release reset and expect no spurious ack.
- Write 1 then 0: write `dat_i=32'h1`, `be_i=4'hF`, and hold strobe until ack.
  - Expect `ack_o` high for exactly 1 cycle, and `gpo_o=1` from the ack cycle onward.
  - Then write 0 and expect `gpo_o=0`.
- Byte-enable masking: write `dat_i=32'h1` with `be_i=4'hE`. Expect ack and `gpo_o` to stay 0. A following read returns `dat_o[1]=0`.
- Input sampling: drive `gpi_i=1`, wait 2 cycles, then read. Expect `dat_o=32'h1` (with `gpo=0`), or `32'h3` after a prior write of 1.
  - A read issued in the same cycle as the `gpi_i` transition returns bit0=0.
- Held strobe: keep `cyc_i=stb_i=1`, `we_i=0` for 6 cycles. Expect the ack pattern 0,1,0,1,0,1 and no consecutive ack cycles.
- Asynchronous reset mid-write: assert `rst_in=0` between strobe and ack, after a prior write of 1.
  - `gpo_o` and `ack_o` drop immediately without waiting for a clock edge: `gpo_o` goes to 0 and `ack_o` stays 0.
  - The latch does not take the aborted data.

Source files
------------

// File: rtl/sync_ff.sv
// N-stage flip-flop synchronizer for bringing an asynchronous level into the clk_i domain.
// All stages clear to 0 on reset; q_o is the last stage.
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_in,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   assign sync_d = {sync_q[STAGES-2:0], d_i};

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fsoc_gpio.sv
// Single-bit GPIO with a Wishbone-classic slave port: one register, bit 0 drives the output
// latch on writes; reads return {latch, synchronized input}.
module fsoc_gpio #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        GPO_RESET   = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_in,
   input  logic        cyc_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] dat_i,
   output logic [31:0] dat_o,
   output logic        ack_o,
   input  logic        gpi_i,
   output logic        gpo_o
);

   localparam int unsigned GPI_BIT = 0;
   localparam int unsigned GPO_BIT = 1;

   logic        ack_q;
   logic        gpo_q;
   logic [31:0] dat_q;
   logic [31:0] rd_data;
   logic        gpi_sync;
   logic        accept;
   logic        gpo_wr;
   logic        unused_bus_bits;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_gpi_sync (
      .clk_i  (clk_i),
      .rst_in (rst_in),
      .d_i    (gpi_i),
      .q_o    (gpi_sync)
   );

   // Blocking on ack_q forces a dead cycle after each ack, so a held strobe is acked 1,0,1,0...
   assign accept = cyc_i & stb_i & ~ack_q;
   assign gpo_wr = accept & we_i & be_i[0];

   always_comb begin
      rd_data          = '0;
      rd_data[GPI_BIT] = gpi_sync;
      rd_data[GPO_BIT] = gpo_q;
   end

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         ack_q <= 1'b0;
         gpo_q <= GPO_RESET;
         dat_q <= '0;
      end else begin
         ack_q <= accept;
         if (accept) begin
            dat_q <= rd_data;
         end
         if (gpo_wr) begin
            gpo_q <= dat_i[0];
         end
      end
   end

   assign unused_bus_bits = ^{dat_i[31:1], be_i[3:1]};

   assign ack_o = ack_q;
   assign dat_o = dat_q;
   assign gpo_o = gpo_q;

endmodule

// File: tb/tb_fsoc_gpio.sv
// Directed bench for fsoc_gpio: a vector table of single accesses plus hand-written
// sequences for reset, input latency, held strobe and reset during an access.
module tb_fsoc_gpio;

   logic        clk_i = 1'b0;
   logic        rst_in = 1'b1;
   logic        cyc_i = 1'b0;
   logic        stb_i = 1'b0;
   logic        we_i = 1'b0;
   logic [3:0]  be_i = 4'h0;
   logic [31:0] dat_i = 32'h0;
   logic [31:0] dat_o;
   logic        ack_o;
   logic        gpi_i = 1'b0;
   logic        gpo_o;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] dat;
      logic        gpi;
      logic [31:0] exp_dat;
      logic        exp_gpo;
   } vec_t;

   vec_t vecs[11];

   fsoc_gpio dut (
      .clk_i  (clk_i),
      .rst_in (rst_in),
      .cyc_i  (cyc_i),
      .stb_i  (stb_i),
      .we_i   (we_i),
      .be_i   (be_i),
      .dat_i  (dat_i),
      .dat_o  (dat_o),
      .ack_o  (ack_o),
      .gpi_i  (gpi_i),
      .gpo_o  (gpo_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic present(input logic we, input logic [3:0] be, input logic [31:0] dat);
      cyc_i = 1'b1;
      stb_i = 1'b1;
      we_i  = we;
      be_i  = be;
      dat_i = dat;
   endtask

   task automatic idle();
      cyc_i = 1'b0;
      stb_i = 1'b0;
      we_i  = 1'b0;
      be_i  = 4'h0;
      dat_i = 32'h0;
   endtask

   initial begin
      //            we    be     dat            gpi   exp_dat  exp_gpo
      vecs[0]  = '{1'b0, 4'hF, 32'h0000_0000, 1'b0, 32'h0, 1'b0};
      vecs[1]  = '{1'b1, 4'hF, 32'h0000_0001, 1'b0, 32'h0, 1'b1};
      vecs[2]  = '{1'b0, 4'hF, 32'h0000_0000, 1'b0, 32'h2, 1'b1};
      vecs[3]  = '{1'b0, 4'h0, 32'h0000_0000, 1'b1, 32'h3, 1'b1};
      vecs[4]  = '{1'b1, 4'hF, 32'h0000_0000, 1'b1, 32'h3, 1'b0};
      vecs[5]  = '{1'b0, 4'hF, 32'h0000_0000, 1'b1, 32'h1, 1'b0};
      vecs[6]  = '{1'b1, 4'hE, 32'h0000_0001, 1'b1, 32'h1, 1'b0};
      vecs[7]  = '{1'b0, 4'hF, 32'h0000_0000, 1'b0, 32'h0, 1'b0};
      vecs[8]  = '{1'b1, 4'hF, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b0};
      vecs[9]  = '{1'b1, 4'h1, 32'h0000_0001, 1'b0, 32'h0, 1'b1};
      vecs[10] = '{1'b0, 4'hF, 32'h0000_0000, 1'b1, 32'h3, 1'b1};

      // Reset held while the bus toggles
      #2 rst_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         present(i[0], 4'hF, 32'h1);
         gpi_i = i[0];
         tick();
         chk("rst_ack", {31'b0, ack_o}, 32'h0);
         chk("rst_dat", dat_o, 32'h0);
         chk("rst_gpo", {31'b0, gpo_o}, 32'h0);
      end
      idle();
      gpi_i = 1'b0;
      rst_in = 1'b1;
      tick();
      chk("rel_ack0", {31'b0, ack_o}, 32'h0);
      tick();
      chk("rel_ack1", {31'b0, ack_o}, 32'h0);

      foreach (vecs[i]) begin
         gpi_i = vecs[i].gpi;
         repeat (3) tick();
         present(vecs[i].we, vecs[i].be, vecs[i].dat);
         tick();
         chk($sformatf("vec%0d_ack", i), {31'b0, ack_o}, 32'h1);
         chk($sformatf("vec%0d_dat", i), dat_o, vecs[i].exp_dat);
         chk($sformatf("vec%0d_gpo", i), {31'b0, gpo_o}, {31'b0, vecs[i].exp_gpo});
         idle();
         tick();
         chk($sformatf("vec%0d_ackoff", i), {31'b0, ack_o}, 32'h0);
         chk($sformatf("vec%0d_hold", i), dat_o, vecs[i].exp_dat);
      end

      // Clear output latch and settle gpi low
      gpi_i = 1'b0;
      present(1'b1, 4'hF, 32'h0);
      tick();
      idle();
      repeat (3) tick();
      chk("pre_gpo", {31'b0, gpo_o}, 32'h0);

      // Read in the same cycle as the gpi rise sees 0; two edges later it sees 1
      gpi_i = 1'b1;
      present(1'b0, 4'hF, 32'h0);
      tick();
      chk("gpi_same_ack", {31'b0, ack_o}, 32'h1);
      chk("gpi_same_dat", dat_o, 32'h0);
      idle();
      tick();
      present(1'b0, 4'hF, 32'h0);
      tick();
      chk("gpi_lat_dat", dat_o, 32'h1);
      idle();
      tick();

      // One edge after the gpi fall, the synchronized value is still 1
      gpi_i = 1'b0;
      tick();
      present(1'b0, 4'hF, 32'h0);
      tick();
      chk("gpi_one_edge", dat_o, 32'h1);
      idle();
      repeat (3) tick();

      // Held strobe: ack alternates, never two in a row
      present(1'b0, 4'hF, 32'h0);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("held_ack%0d", k), {31'b0, ack_o}, (k % 2 == 0) ? 32'h1 : 32'h0);
      end
      idle();
      tick();

      // Async reset between strobe and ack, after a prior write of 1
      present(1'b1, 4'hF, 32'h1);
      tick();
      idle();
      tick();
      chk("mid_pre_gpo", {31'b0, gpo_o}, 32'h1);
      present(1'b1, 4'hF, 32'h1);
      tick();
      chk("mid_ack_first", {31'b0, ack_o}, 32'h1);
      idle();
      tick();
      present(1'b1, 4'hF, 32'h1);
      #2 rst_in = 1'b0;
      #1;
      chk("mid_gpo_async", {31'b0, gpo_o}, 32'h0);
      chk("mid_ack_async", {31'b0, ack_o}, 32'h0);
      chk("mid_dat_async", dat_o, 32'h0);
      tick();
      chk("mid_gpo_inrst", {31'b0, gpo_o}, 32'h0);
      chk("mid_ack_inrst", {31'b0, ack_o}, 32'h0);
      present(1'b0, 4'hF, 32'h0);
      rst_in = 1'b1;
      #1;
      chk("mid_gpo_rel", {31'b0, gpo_o}, 32'h0);
      chk("mid_ack_rel", {31'b0, ack_o}, 32'h0);
      tick();
      chk("mid_new_ack", {31'b0, ack_o}, 32'h1);
      chk("mid_new_dat", dat_o, 32'h0);
      chk("mid_new_gpo", {31'b0, gpo_o}, 32'h0);
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
